data_mem_responder: RTL

//  Responder end of the CPU data-memory port: services dmem_addr/we/re/byte_en requests from the
//  MEM stage with zero-wait combinational read data and clocked byte-lane writes. Sits beside the
//  CPU in the SoC/testbench top. Also decodes a small MMIO window: tohost, cycle counter, scratch.

---
 rtl/data_mem_responder.sv | 84 ++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory responder (RAM, byte lanes, MMIO tohost/cycle/scratch); optional DMEM_MISALIGN_CHECK_EN
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    input  logic        dmem_re,
    input  logic [3:0]  dmem_byte_en,
    output logic [31:0] dmem_rdata,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        misalign_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [3:0]    mask;
    logic [31:0]   wlanes, bmask, mmio_word, sel_word;
    logic          is_mmio, misaligned, wr, tohost_hit, scratch_hit;
    logic [31:0]   tohost_data_q, tohost_data_d, cycle_q, cycle_d, scratch_q, scratch_d;
    logic          tohost_valid_q, tohost_valid_d, misalign_err_q, misalign_err_d;
    logic          unused_ok;

    assign unused_ok    = ^{dmem_addr[30:AW+2], MMIO_BASE};
    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign misalign_err = misalign_err_q;

    // Address decode, lane alignment and zero-wait read mux
    always_comb begin
        off         = dmem_addr[1:0];
        idx         = dmem_addr[AW+1:2];
        is_mmio     = dmem_addr[31];
        mask        = dmem_byte_en << off;
`ifdef DMEM_MISALIGN_CHECK_EN
        misaligned  = (dmem_byte_en == 4'b0011 && off[0]) || (dmem_byte_en == 4'b1111 && off != 2'd0);
`else
        misaligned  = 1'b0;
`endif
        wr          = dmem_we && !misaligned;
        wlanes      = dmem_wdata << {off, 3'b000};
        bmask       = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        tohost_hit  = wr && is_mmio && dmem_addr[3:2] == 2'd0;
        scratch_hit = wr && is_mmio && dmem_addr[3:2] == 2'd2;
        mmio_word   = dmem_addr[3:2] == 2'd0 ? tohost_data_q :
                      dmem_addr[3:2] == 2'd1 ? cycle_q :
                      dmem_addr[3:2] == 2'd2 ? scratch_q : 32'h0;
        sel_word    = is_mmio ? mmio_word : mem[idx];
        dmem_rdata  = (dmem_re && !misaligned) ? sel_word >> {off, 3'b000} : 32'h0;
    end

    // Next state of MMIO registers, cycle counter and sticky error; reset dominates writes
    always_comb begin
        tohost_data_d  = rst ? 32'h0 : tohost_hit ? (tohost_data_q & ~bmask) | (wlanes & bmask) : tohost_data_q;
        tohost_valid_d = !rst && tohost_hit;
        scratch_d      = rst ? 32'h0 : scratch_hit ? (scratch_q & ~bmask) | (wlanes & bmask) : scratch_q;
        cycle_d        = rst ? 32'h0 : cycle_q + 32'd1;
        misalign_err_d = !rst && (misalign_err_q || (misaligned && (dmem_we || dmem_re)));
    end

    // Register update
    always_ff @(posedge clk) begin
        tohost_data_q  <= tohost_data_d;
        tohost_valid_q <= tohost_valid_d;
        scratch_q      <= scratch_d;
        cycle_q        <= cycle_d;
        misalign_err_q <= misalign_err_d;
    end

    // Byte-lane RAM write; RAM contents survive reset but writes during reset are dropped
    always_ff @(posedge clk) begin
        if (!rst && wr && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end
endmodule
